// File: rtl/bcdtime_set_ctl.sv
// Time-set sequencer for the bcdtime counter: arbitrates two requesters, validates the
// requested BCD time and applies it on the next 1 PPS strobe, then answers with ack or nak.

package bcdtime_pkg;

    typedef struct packed {
        logic [3:0] t_10h;
        logic [3:0] t_1h;
        logic [3:0] t_10m;
        logic [3:0] t_1m;
        logic [3:0] t_10s;
        logic [3:0] t_1s;
        logic [3:0] t_100ms;
        logic [3:0] t_10ms;
        logic [3:0] t_1ms;
    } time_t;

endpackage

module bcdtime_set_ctl
    import bcdtime_pkg::*;
#(
    parameter int unsigned TIMEOUT_MS = 2000,
    parameter bit          ARB_RR     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tsc_1pps,
    input  logic       tsc_1ppms,
    input  logic [1:0] req,
    input  time_t      req_time0,
    input  time_t      req_time1,
    output logic [1:0] ack,
    output logic [1:0] nak,
    output logic [1:0] nak_code,
    output logic       busy,
    output logic       set,
    output time_t      set_time
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_MS);
    localparam logic [1:0]  CODE_BCD    = 2'd1;
    localparam logic [1:0]  CODE_TMO    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_PPS,
        S_RESP,
        S_WAIT_REL
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_q, rr_d;
    time_t       set_time_q, set_time_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  nak_q, nak_d;
    logic [1:0]  nak_code_q, nak_code_d;

    logic [15:0] to_cnt_inc;
    logic        time_ok;

    function automatic logic bcd_time_valid(input time_t t);
        logic digits_ok;
        logic range_ok;
        digits_ok = (t.t_10h <= 4'd9) && (t.t_1h <= 4'd9) && (t.t_10m <= 4'd9) &&
                    (t.t_1m <= 4'd9) && (t.t_10s <= 4'd9) && (t.t_1s <= 4'd9) &&
                    (t.t_100ms <= 4'd9) && (t.t_10ms <= 4'd9) && (t.t_1ms <= 4'd9);
        range_ok  = (t.t_10s <= 4'd5) && (t.t_10m <= 4'd5) && (t.t_10h <= 4'd2) &&
                    !((t.t_10h == 4'd2) && (t.t_1h > 4'd3));
        return digits_ok && range_ok;
    endfunction

    assign time_ok    = bcd_time_valid(set_time_q);
    // Saturate rather than wrap so a very late pps can never look like a fresh count.
    assign to_cnt_inc = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        set_time_d = set_time_q;
        to_cnt_d   = to_cnt_q;
        ack_d      = 2'b00;
        nak_d      = 2'b00;
        nak_code_d = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    if (req == 2'b11) grant_d = ARB_RR ? ~rr_q : 1'b0;
                    else              grant_d = req[1];
                    set_time_d         = grant_d ? req_time1 : req_time0;
                    set_time_d.t_100ms = 4'd0;
                    set_time_d.t_10ms  = 4'd0;
                    set_time_d.t_1ms   = 4'd0;
                    state_d            = S_CHECK;
                end
            end
            S_CHECK: begin
                if (time_ok) begin
                    to_cnt_d = 16'd0;
                    state_d  = S_WAIT_PPS;
                end else begin
                    nak_d[grant_q] = 1'b1;
                    nak_code_d     = CODE_BCD;
                    state_d        = S_RESP;
                end
            end
            S_WAIT_PPS: begin
                // The pps takes precedence over both a cancel and the final ms strobe.
                if (tsc_1pps) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_RESP;
                end else if (!req[grant_q]) begin
                    state_d = S_IDLE;
                end else if (tsc_1ppms) begin
                    to_cnt_d = to_cnt_inc;
                    if (to_cnt_inc >= TIMEOUT_CNT) begin
                        nak_d[grant_q] = 1'b1;
                        nak_code_d     = CODE_TMO;
                        state_d        = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rr_d    = grant_q;
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!req[grant_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            set_time_q <= '0;
            to_cnt_q   <= 16'd0;
            ack_q      <= 2'b00;
            nak_q      <= 2'b00;
            nak_code_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            set_time_q <= set_time_d;
            to_cnt_q   <= to_cnt_d;
            ack_q      <= ack_d;
            nak_q      <= nak_d;
            nak_code_q <= nak_code_d;
        end
    end

    // set is combinational so it coincides with the pps cycle that bcdtime acts on.
    assign set      = (state_q == S_WAIT_PPS) && tsc_1pps;
    assign set_time = set_time_q;
    assign busy     = (state_q != S_IDLE);
    assign ack      = ack_q;
    assign nak      = nak_q;
    assign nak_code = nak_code_q;

endmodule

// File: tb/tb_bcdtime_set_ctl.sv
// Directed bench for bcdtime_set_ctl: a vector table of single requests plus
// hand-written sequences for arbitration, cancel and mid-operation reset.

module tb_bcdtime_set_ctl;
    import bcdtime_pkg::*;

    logic       clk;
    logic       rst;
    logic       pps;
    logic       ppms;
    logic [1:0] req_fp;
    logic [1:0] req_rr;
    time_t      t0;
    time_t      t1;

    logic [1:0] fp_ack, fp_nak, fp_code;
    logic       fp_busy, fp_set;
    time_t      fp_set_time;
    logic [1:0] rr_ack, rr_nak, rr_code;
    logic       rr_busy, rr_set;
    time_t      rr_set_time;

    int n_vec = 0;
    int n_err = 0;

    bcdtime_set_ctl #(.TIMEOUT_MS(5), .ARB_RR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .tsc_1pps(pps), .tsc_1ppms(ppms), .req(req_fp),
        .req_time0(t0), .req_time1(t1), .ack(fp_ack), .nak(fp_nak), .nak_code(fp_code),
        .busy(fp_busy), .set(fp_set), .set_time(fp_set_time)
    );

    bcdtime_set_ctl #(.TIMEOUT_MS(5), .ARB_RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .tsc_1pps(pps), .tsc_1ppms(ppms), .req(req_rr),
        .req_time0(t0), .req_time1(t1), .ack(rr_ack), .nak(rr_nak), .nak_code(rr_code),
        .busy(rr_busy), .set(rr_set), .set_time(rr_set_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        time_t      tm;
        int         pps_a;     // cycle of a pps strobe, -1 for none
        int         pps_b;
        bit         ms_en;     // ms strobe on every even cycle from 2
        logic [1:0] e_ack;
        logic [1:0] e_nak;
        logic [1:0] e_code;
        int         e_set_cyc;
        int         e_resp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic time_t mk(input logic [3:0] h10, input logic [3:0] h1, input logic [3:0] m10,
                                 input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
        // Non-zero sub-second digits so the forced clear is visible.
        return '{h10, h1, m10, m1, s10, s1, 4'h7, 4'h8, 4'h9};
    endfunction

    function automatic time_t clr_ms(input time_t t);
        time_t r;
        r = t;
        r.t_100ms = 4'h0;
        r.t_10ms  = 4'h0;
        r.t_1ms   = 4'h0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_fp = 2'b00;
        req_rr = 2'b00;
        pps    = 1'b0;
        ppms   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         set_cnt, set_cyc, resp_cyc;
        logic [1:0] got_ack, got_nak, got_code;
        logic       busy_r;
        time_t      set_tm;
        do_reset();
        req_fp   = v.req;
        t0       = v.tm;
        t1       = v.tm;
        set_cnt  = 0;
        set_cyc  = -1;
        resp_cyc = -1;
        got_ack  = 2'b00;
        got_nak  = 2'b00;
        got_code = 2'd0;
        busy_r   = 1'b0;
        set_tm   = '0;
        for (int c = 0; c < 40; c++) begin
            pps  = (c == v.pps_a) || (c == v.pps_b);
            ppms = v.ms_en && (c >= 2) && (c % 2 == 0);
            @(negedge clk);
            if (fp_set) begin
                set_cnt++;
                set_cyc = c;
                set_tm  = fp_set_time;
            end
            if ((fp_ack | fp_nak) != 2'b00) begin
                got_ack  = fp_ack;
                got_nak  = fp_nak;
                got_code = fp_code;
                resp_cyc = c;
                busy_r   = fp_busy;
            end
            tick();
            if (resp_cyc >= 0) break;
        end
        pps    = 1'b0;
        ppms   = 1'b0;
        req_fp = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_ack", idx), 64'(got_ack), 64'(v.e_ack));
        check($sformatf("v%0d_nak", idx), 64'(got_nak), 64'(v.e_nak));
        check($sformatf("v%0d_code", idx), 64'(got_code), 64'(v.e_code));
        check($sformatf("v%0d_resp_cyc", idx), 64'(resp_cyc), 64'(v.e_resp_cyc));
        check($sformatf("v%0d_set_cnt", idx), 64'(set_cnt), 64'((v.e_set_cyc >= 0) ? 1 : 0));
        check($sformatf("v%0d_set_cyc", idx), 64'(set_cyc), 64'(v.e_set_cyc));
        if (v.e_set_cyc >= 0) check($sformatf("v%0d_set_time", idx), 64'(set_tm), 64'(clr_ms(v.tm)));
        check($sformatf("v%0d_busy_resp", idx), 64'(busy_r), 64'(1));
        check($sformatf("v%0d_busy_after", idx), 64'(fp_busy), 64'(0));
    endtask

    initial begin
        int    n_set, n_ack, drop_c, rearm_c, ev_cnt;
        int    s_cyc[4];
        time_t s_tm[4];
        int    a_cyc[4];
        logic [1:0] a_bits[4];
        logic [1:0] drop_mask;
        logic  b3, b5;

        //               req    time                                  ppsA ppsB ms  ack    nak    code set resp
        vecs[0] = '{2'b01, mk(4'h2, 4'h3, 4'h5, 4'h9, 4'h5, 4'h9),  5, -1, 1'b0, 2'b01, 2'b00, 2'd0,  5,  6};
        vecs[1] = '{2'b10, mk(4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0),  3, -1, 1'b0, 2'b00, 2'b10, 2'd1, -1,  2};
        vecs[2] = '{2'b10, mk(4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h0),  3, -1, 1'b0, 2'b00, 2'b10, 2'd1, -1,  2};
        vecs[3] = '{2'b10, mk(4'h1, 4'h2, 4'h3, 4'hA, 4'h0, 4'h0),  3, -1, 1'b0, 2'b00, 2'b10, 2'd1, -1,  2};
        vecs[4] = '{2'b01, mk(4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0),  3, -1, 1'b0, 2'b00, 2'b01, 2'd1, -1,  2};
        vecs[5] = '{2'b01, mk(4'h0, 4'h8, 4'h1, 4'h5, 4'h3, 4'h0), -1, -1, 1'b1, 2'b00, 2'b01, 2'd2, -1, 11};
        vecs[6] = '{2'b01, mk(4'h0, 4'h8, 4'h1, 4'h5, 4'h3, 4'h0), 10, -1, 1'b1, 2'b01, 2'b00, 2'd0, 10, 11};
        vecs[7] = '{2'b01, mk(4'h1, 4'h9, 4'h0, 4'h9, 4'h0, 4'h9),  1,  8, 1'b0, 2'b01, 2'b00, 2'd0,  8,  9};
        vecs[8] = '{2'b10, mk(4'h0, 4'h9, 4'h0, 4'h5, 4'h0, 4'h7),  4, -1, 1'b0, 2'b10, 2'b00, 2'd0,  4,  5};
        vecs[9] = '{2'b11, mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0),  2, -1, 1'b0, 2'b01, 2'b00, 2'd0,  2,  3};

        // Reset values on both instances.
        rst = 1'b1; req_fp = 2'b00; req_rr = 2'b00; pps = 1'b0; ppms = 1'b0;
        t0 = '0; t1 = '0;
        repeat (2) tick();
        check("rst_fp_outs", 64'({fp_ack, fp_nak, fp_code, fp_busy, fp_set}), 64'(0));
        check("rst_fp_time", 64'(fp_set_time), 64'(0));
        check("rst_rr_outs", 64'({rr_ack, rr_nak, rr_code, rr_busy, rr_set}), 64'(0));

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Fixed priority tie: req0 then req1, sets on consecutive pps strobes.
        do_reset();
        t0 = mk(4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3);
        t1 = mk(4'h0, 4'h4, 4'h0, 4'h5, 4'h0, 4'h6);
        req_fp = 2'b11; n_set = 0; n_ack = 0; ev_cnt = 0; drop_mask = 2'b00;
        for (int c = 0; c < 60; c++) begin
            pps = (c % 20 == 6);
            @(negedge clk);
            if (fp_set && n_set < 4) begin s_cyc[n_set] = c; s_tm[n_set] = fp_set_time; n_set++; end
            if (fp_ack != 2'b00 && n_ack < 4) begin a_cyc[n_ack] = c; a_bits[n_ack] = fp_ack; n_ack++; end
            if (fp_nak != 2'b00) ev_cnt++;
            drop_mask = drop_mask | fp_ack;
            tick();
            req_fp = req_fp & ~drop_mask;
        end
        pps = 1'b0;
        check("fp_tie_set_cnt", 64'(n_set), 64'(2));
        check("fp_tie_ack_cnt", 64'(n_ack), 64'(2));
        check("fp_tie_nak_cnt", 64'(ev_cnt), 64'(0));
        if (n_set == 2 && n_ack == 2) begin
            check("fp_tie_set0_cyc", 64'(s_cyc[0]), 64'(6));
            check("fp_tie_set0_time", 64'(s_tm[0]), 64'(clr_ms(t0)));
            check("fp_tie_set1_cyc", 64'(s_cyc[1]), 64'(26));
            check("fp_tie_set1_time", 64'(s_tm[1]), 64'(clr_ms(t1)));
            check("fp_tie_ack0", 64'({a_bits[0], 8'(a_cyc[0])}), 64'({2'b01, 8'd7}));
            check("fp_tie_ack1", 64'({a_bits[1], 8'(a_cyc[1])}), 64'({2'b10, 8'd27}));
        end

        // Round-robin ties: the requester other than the last served wins each time.
        do_reset();
        req_rr = 2'b11; n_set = 0; n_ack = 0; drop_c = -1; rearm_c = -1;
        for (int c = 0; c < 60; c++) begin
            if (c == drop_c) req_rr = 2'b00;
            if (c == rearm_c) req_rr = 2'b11;
            pps = (c % 20 == 6);
            @(negedge clk);
            if (rr_set && n_set < 4) begin s_cyc[n_set] = c; s_tm[n_set] = rr_set_time; n_set++; end
            if (rr_ack != 2'b00 && n_ack < 4) begin
                a_cyc[n_ack] = c; a_bits[n_ack] = rr_ack; n_ack++;
                drop_c = c + 1; rearm_c = c + 5;
            end
            tick();
        end
        pps = 1'b0;
        check("rr_set_cnt", 64'(n_set), 64'(3));
        check("rr_ack_cnt", 64'(n_ack), 64'(3));
        if (n_set == 3 && n_ack == 3) begin
            check("rr_set0", 64'({8'(s_cyc[0]), s_tm[0]}), 64'({8'd6, clr_ms(t1)}));
            check("rr_set1", 64'({8'(s_cyc[1]), s_tm[1]}), 64'({8'd26, clr_ms(t0)}));
            check("rr_set2", 64'({8'(s_cyc[2]), s_tm[2]}), 64'({8'd46, clr_ms(t1)}));
            check("rr_ack_bits", 64'({a_bits[0], a_bits[1], a_bits[2]}), 64'(6'b10_01_10));
        end

        // Cancel during WAIT_PPS: no set, no response, back to idle.
        do_reset();
        req_fp = 2'b01; t0 = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
        n_set = 0; ev_cnt = 0; b3 = 1'b0; b5 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) req_fp = 2'b00;
            pps = (c == 8);
            @(negedge clk);
            if (fp_set) n_set++;
            if ((fp_ack | fp_nak) != 2'b00) ev_cnt++;
            if (c == 3) b3 = fp_busy;
            if (c == 5) b5 = fp_busy;
            tick();
        end
        pps = 1'b0;
        check("cancel_set_cnt", 64'(n_set), 64'(0));
        check("cancel_resp_cnt", 64'(ev_cnt), 64'(0));
        check("cancel_busy_wait", 64'(b3), 64'(1));
        check("cancel_busy_idle", 64'(b5), 64'(0));

        // Reset during WAIT_PPS: outputs clear at once, pps under reset ignored, request re-served.
        do_reset();
        req_fp = 2'b01; t0 = mk(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        n_set = 0; n_ack = 0; s_cyc[0] = -1; a_cyc[0] = -1; s_tm[0] = '0; drop_mask = 2'b00;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) begin
                rst = 1'b1;
                #1;
                check("midrst_outs", 64'({fp_ack, fp_nak, fp_code, fp_busy, fp_set}), 64'(0));
                check("midrst_time", 64'(fp_set_time), 64'(0));
            end
            if (c == 7) rst = 1'b0;
            pps = (c == 5) || (c == 12);
            @(negedge clk);
            if (fp_set) begin
                if (n_set == 0) begin s_cyc[0] = c; s_tm[0] = fp_set_time; end
                n_set++;
            end
            if (fp_ack != 2'b00) begin
                if (n_ack == 0) a_cyc[0] = c;
                n_ack++;
            end
            drop_mask = drop_mask | fp_ack;
            tick();
            req_fp = req_fp & ~drop_mask;
        end
        pps = 1'b0;
        check("midrst_set_cnt", 64'(n_set), 64'(1));
        check("midrst_set_cyc", 64'(s_cyc[0]), 64'(12));
        check("midrst_set_time", 64'(s_tm[0]), 64'(clr_ms(t0)));
        check("midrst_ack_cyc", 64'(a_cyc[0]), 64'(13));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
